// File: rtl/lbist_pkg.sv
// Shared types and helpers for the logic-BIST sequencer.
// Latency: n/a (types, constants and a combinational step function only).
// Backpressure: n/a.
package lbist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } lbist_state_e;

    // Widest LFSR/MISR the step helper supports.
    localparam int unsigned LBIST_MAX_W = 64;

    // x^32 + x^22 + x^2 + x + 1, with x^32 implicit.
    localparam logic [31:0] LBIST_POLY_DEFAULT = 32'h0040_0007;

    // One Galois step of a w-bit register held in the low bits of x.
    // Bits at and above w are forced to zero in the result.
    function automatic logic [LBIST_MAX_W-1:0] lfsr_step(
        input logic [LBIST_MAX_W-1:0] x,
        input logic [LBIST_MAX_W-1:0] poly,
        input int unsigned            w
    );
        logic [LBIST_MAX_W-1:0] mask;
        logic [LBIST_MAX_W-1:0] shifted;
        logic [5:0]             msb_idx;
        msb_idx = w[5:0] - 6'd1;
        mask    = (w >= LBIST_MAX_W) ? '1
                : ((LBIST_MAX_W'(1) << w) - LBIST_MAX_W'(1));
        shifted = {x[LBIST_MAX_W-2:0], 1'b0};
        lfsr_step = (shifted ^ (x[msb_idx] ? poly : '0)) & mask;
    endfunction

endpackage

// File: rtl/lbist_misr.sv
// Multiple-input signature register: sig <= step(sig) ^ data_i while enabled.
// Latency: one cycle from data_i to sig_o; clear_i wins over enable_i.
// Backpressure: none; every enabled cycle is absorbed.
//
// Ports: clk/rst_n (async active-low), clear_i zeroes the signature,
// enable_i compacts data_i, sig_o is the registered signature.
module lbist_misr
    import lbist_pkg::*;
#(
    parameter int unsigned    W    = 32,
    parameter logic [W-1:0]   POLY = W'(LBIST_POLY_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] sig_o
);

    logic [W-1:0]           sig_q;
    logic [W-1:0]           sig_d;
    logic [LBIST_MAX_W-1:0] sig_wide;
    logic                   unused_sig_hi;

    assign sig_wide      = lfsr_step(LBIST_MAX_W'(sig_q), LBIST_MAX_W'(POLY), W);
    // Upper bits are always zero for W < LBIST_MAX_W.
    assign unused_sig_hi = ^sig_wide;

    always_comb begin
        sig_d = sig_q;
        if (clear_i) begin
            sig_d = '0;
        end else if (enable_i) begin
            sig_d = sig_wide[W-1:0] ^ data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/lbist_ctrl.sv
// Logic-BIST sequencer: seeds an LFSR, runs N_PATTERNS cycles into a MISR, checks the signature.
// Latency: start edge at edge k -> done_o high after edge k+SETTLE_CYCLES+N_PATTERNS+2.
// Backpressure: none; start edges arriving while a test is in flight are dropped.
//
// Ports: start_i (level, rising edge starts), response_i (compacted in RUN),
// pattern_o (LFSR stimulus), test_mode_o/core_rst_no (core isolation controls),
// busy_o/done_o/go_nogo_o (status), signature_o (MISR), pattern_cnt_o (RUN cycles done).
module lbist_ctrl
    import lbist_pkg::*;
#(
    parameter int unsigned  W             = 32,
    parameter logic [W-1:0] POLY          = W'(LBIST_POLY_DEFAULT),
    parameter logic [W-1:0] LFSR_SEED     = W'(1),
    parameter int unsigned  N_PATTERNS    = 1024,
    parameter int unsigned  SETTLE_CYCLES = 4,
    parameter logic [W-1:0] GOLDEN_SIG    = '0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic [W-1:0]                      response_i,
    output logic [W-1:0]                      pattern_o,
    output logic                              test_mode_o,
    output logic                              core_rst_no,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              go_nogo_o,
    output logic [W-1:0]                      signature_o,
    output logic [$clog2(N_PATTERNS+1)-1:0]   pattern_cnt_o
);

    localparam int unsigned CNT_W = $clog2(N_PATTERNS + 1);
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("lbist_ctrl: LFSR_SEED must be nonzero");
    end
    if (N_PATTERNS < 1) begin : g_bad_npat
        $error("lbist_ctrl: N_PATTERNS must be >= 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("lbist_ctrl: SETTLE_CYCLES must be >= 1");
    end
    if (W < 2 || W > LBIST_MAX_W) begin : g_bad_width
        $error("lbist_ctrl: W out of range");
    end

    lbist_state_e           state_q, state_d;
    logic                   start_q;
    logic [SET_W-1:0]       settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]       pattern_cnt_q, pattern_cnt_d;
    logic [W-1:0]           lfsr_q, lfsr_d;
    logic                   busy_q, busy_d;
    logic                   test_mode_q, test_mode_d;
    logic                   core_rst_n_q, core_rst_n_d;
    logic                   done_q, done_d;
    logic                   go_nogo_q, go_nogo_d;
    logic                   misr_clear, misr_en;
    logic [W-1:0]           misr_sig;
    logic                   start_edge;
    logic [LBIST_MAX_W-1:0] lfsr_wide;
    logic                   unused_lfsr_hi;

    assign start_edge     = start_i & ~start_q;
    assign lfsr_wide      = lfsr_step(LBIST_MAX_W'(lfsr_q), LBIST_MAX_W'(POLY), W);
    assign unused_lfsr_hi = ^lfsr_wide;

    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        pattern_cnt_d = pattern_cnt_q;
        lfsr_d        = lfsr_q;
        go_nogo_d     = go_nogo_q;
        misr_clear    = 1'b0;
        misr_en       = 1'b0;

        // Status/control outputs are a registered decode of the current
        // state, so they trail the state register by one cycle. The one
        // exception is done_o, which drops on the starting edge itself.
        busy_d       = (state_q == ST_INIT) || (state_q == ST_RUN) || (state_q == ST_COMPARE);
        test_mode_d  = busy_d;
        core_rst_n_d = !((state_q == ST_INIT) || (state_q == ST_COMPARE));
        done_d       = (state_q == ST_DONE) && !start_edge;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                settle_cnt_d = '0;
                if (start_edge) begin
                    state_d   = ST_INIT;
                    go_nogo_d = 1'b0;
                end
            end
            ST_INIT: begin
                lfsr_d        = LFSR_SEED;
                misr_clear    = 1'b1;
                pattern_cnt_d = '0;
                if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end
            ST_RUN: begin
                lfsr_d  = lfsr_wide[W-1:0];
                misr_en = 1'b1;
                if (pattern_cnt_q != CNT_W'(N_PATTERNS)) begin
                    pattern_cnt_d = pattern_cnt_q + CNT_W'(1);
                end
                if (pattern_cnt_q == CNT_W'(N_PATTERNS - 1)) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                go_nogo_d = (misr_sig == GOLDEN_SIG);
                state_d   = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            start_q       <= 1'b0;
            settle_cnt_q  <= '0;
            pattern_cnt_q <= '0;
            lfsr_q        <= '0;
            busy_q        <= 1'b0;
            test_mode_q   <= 1'b0;
            core_rst_n_q  <= 1'b1;
            done_q        <= 1'b0;
            go_nogo_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_i;
            settle_cnt_q  <= settle_cnt_d;
            pattern_cnt_q <= pattern_cnt_d;
            lfsr_q        <= lfsr_d;
            busy_q        <= busy_d;
            test_mode_q   <= test_mode_d;
            core_rst_n_q  <= core_rst_n_d;
            done_q        <= done_d;
            go_nogo_q     <= go_nogo_d;
        end
    end

    lbist_misr #(
        .W    (W),
        .POLY (POLY)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (misr_clear),
        .enable_i (misr_en),
        .data_i   (response_i),
        .sig_o    (misr_sig)
    );

    assign pattern_o     = lfsr_q;
    assign test_mode_o   = test_mode_q;
    assign core_rst_no   = core_rst_n_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign go_nogo_o     = go_nogo_q;
    assign signature_o   = misr_sig;
    assign pattern_cnt_o = pattern_cnt_q;

endmodule

// File: tb/tb_lbist_ctrl.sv
// Directed bench for lbist_ctrl: three instances (matching golden, mismatching
// golden, MSB-set seed) share clock, reset and start.
module tb_lbist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] resp_one;
    logic [31:0] resp_zero;

    logic [31:0] a_pat, a_sig, b_pat, b_sig, c_pat, c_sig;
    logic        a_tm, a_crn, a_busy, a_done, a_go;
    logic        b_tm, b_crn, b_busy, b_done, b_go;
    logic        c_tm, c_crn, c_busy, c_done, c_go;
    logic [3:0]  a_cnt, b_cnt;
    logic [1:0]  c_cnt;

    int checks = 0;
    int errors = 0;

    assign resp_one  = 32'h0000_0001;
    assign resp_zero = 32'h0000_0000;

    always #5 clk = ~clk;

    lbist_ctrl #(.W(32), .POLY(32'h0040_0007), .LFSR_SEED(32'h0000_0001),
                 .N_PATTERNS(8), .SETTLE_CYCLES(2), .GOLDEN_SIG(32'h0000_00FF)) u_a (
        .clk(clk), .rst_n(rst_n), .start_i(start), .response_i(resp_one),
        .pattern_o(a_pat), .test_mode_o(a_tm), .core_rst_no(a_crn), .busy_o(a_busy),
        .done_o(a_done), .go_nogo_o(a_go), .signature_o(a_sig), .pattern_cnt_o(a_cnt));

    lbist_ctrl #(.W(32), .POLY(32'h0040_0007), .LFSR_SEED(32'h0000_0001),
                 .N_PATTERNS(8), .SETTLE_CYCLES(2), .GOLDEN_SIG(32'h0000_00FE)) u_b (
        .clk(clk), .rst_n(rst_n), .start_i(start), .response_i(resp_one),
        .pattern_o(b_pat), .test_mode_o(b_tm), .core_rst_no(b_crn), .busy_o(b_busy),
        .done_o(b_done), .go_nogo_o(b_go), .signature_o(b_sig), .pattern_cnt_o(b_cnt));

    lbist_ctrl #(.W(32), .POLY(32'h0040_0007), .LFSR_SEED(32'h8000_0000),
                 .N_PATTERNS(2), .SETTLE_CYCLES(2), .GOLDEN_SIG(32'h0000_0000)) u_c (
        .clk(clk), .rst_n(rst_n), .start_i(start), .response_i(resp_zero),
        .pattern_o(c_pat), .test_mode_o(c_tm), .core_rst_no(c_crn), .busy_o(c_busy),
        .done_o(c_done), .go_nogo_o(c_go), .signature_o(c_sig), .pattern_cnt_o(c_cnt));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_a_pat(input int i);
        if (i <= 1)      return 32'h1;
        else if (i <= 9) return 32'h1 << (i - 2);
        else             return 32'h100;
    endfunction

    initial begin
        // Reset state
        tick(1);
        chk("rst_a_pat",  a_pat, 32'h0);
        chk("rst_a_sig",  a_sig, 32'h0);
        chk("rst_a_go",   32'(a_go), 32'h0);
        chk("rst_a_done", 32'(a_done), 32'h0);
        chk("rst_a_busy", 32'(a_busy), 32'h0);
        chk("rst_a_tm",   32'(a_tm), 32'h0);
        chk("rst_a_crn",  32'(a_crn), 32'h1);
        chk("rst_a_cnt",  32'(a_cnt), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // First full test; edge k is the first tick after start rises.
        start = 1'b1;
        tick(1);
        chk("k_a_busy", 32'(a_busy), 32'h0);
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            chk($sformatf("run1_a_busy_%0d", i), 32'(a_busy), 32'(i <= 11));
            chk($sformatf("run1_a_done_%0d", i), 32'(a_done), 32'(i == 12));
            chk($sformatf("run1_a_crn_%0d", i), 32'(a_crn),
                32'(!(i == 1 || i == 2 || i == 11)));
            chk($sformatf("run1_c_busy_%0d", i), 32'(c_busy), 32'(i <= 5));
            chk($sformatf("run1_c_done_%0d", i), 32'(c_done), 32'(i >= 6));
            if (i <= 11) begin
                chk($sformatf("run1_a_pat_%0d", i), a_pat, exp_a_pat(i));
                chk($sformatf("run1_a_tm_%0d", i), 32'(a_tm), 32'h1);
            end
            if (i >= 3 && i <= 10) begin
                chk($sformatf("run1_a_cnt_%0d", i), 32'(a_cnt), 32'(i - 2));
            end
            if (i == 2) chk("run1_c_pat_seed", c_pat, 32'h8000_0000);
            if (i == 3) chk("run1_c_pat_wrap", c_pat, 32'h0040_0007);
        end
        chk("run1_a_sig",  a_sig, 32'h0000_00FF);
        chk("run1_a_go",   32'(a_go), 32'h1);
        chk("run1_a_cnt",  32'(a_cnt), 32'h8);
        chk("run1_a_tm",   32'(a_tm), 32'h0);
        chk("run1_b_done", 32'(b_done), 32'h1);
        chk("run1_b_go",   32'(b_go), 32'h0);
        chk("run1_b_sig",  b_sig, 32'h0000_00FF);
        chk("run1_c_sig",  c_sig, 32'h0);
        chk("run1_c_go",   32'(c_go), 32'h1);
        chk("run1_c_cnt",  32'(c_cnt), 32'h2);

        // start_i held high through DONE: no retrigger.
        tick(5);
        chk("hold_a_busy", 32'(a_busy), 32'h0);
        chk("hold_a_done", 32'(a_done), 32'h1);
        chk("hold_a_go",   32'(a_go), 32'h1);
        start = 1'b0;
        tick(1);
        chk("low_a_done", 32'(a_done), 32'h1);
        start = 1'b1;
        tick(1);                              // edge k'
        chk("retrig_a_done", 32'(a_done), 32'h0);
        chk("retrig_a_go",   32'(a_go), 32'h0);
        chk("retrig_b_done", 32'(b_done), 32'h0);
        tick(1);
        chk("retrig_a_busy", 32'(a_busy), 32'h1);
        tick(2);                              // k'+3
        start = 1'b0;
        tick(1);                              // k'+4
        start = 1'b1;
        tick(1);                              // k'+5: edge lands in RUN, ignored
        chk("inj_a_cnt", 32'(a_cnt), 32'h3);
        tick(6);                              // k'+11
        chk("inj_a_done_early", 32'(a_done), 32'h0);
        chk("inj_a_busy",       32'(a_busy), 32'h1);
        tick(1);                              // k'+12
        chk("inj_a_done", 32'(a_done), 32'h1);
        chk("inj_a_busy_end", 32'(a_busy), 32'h0);
        chk("inj_a_sig",  a_sig, 32'h0000_00FF);
        chk("inj_a_go",   32'(a_go), 32'h1);
        chk("inj_c_done", 32'(c_done), 32'h1);

        // Asynchronous reset during RUN at cnt=3.
        start = 1'b0;
        tick(1);
        start = 1'b1;
        tick(1);                              // edge k''
        tick(5);
        chk("mid_a_cnt", 32'(a_cnt), 32'h3);
        chk("mid_a_crn", 32'(a_crn), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_a_busy", 32'(a_busy), 32'h0);
        chk("arst_a_tm",   32'(a_tm), 32'h0);
        chk("arst_a_crn",  32'(a_crn), 32'h1);
        chk("arst_a_go",   32'(a_go), 32'h0);
        chk("arst_a_done", 32'(a_done), 32'h0);
        chk("arst_a_pat",  a_pat, 32'h0);
        chk("arst_a_sig",  a_sig, 32'h0);
        chk("arst_a_cnt",  32'(a_cnt), 32'h0);
        start = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        chk("post_a_done", 32'(a_done), 32'h0);
        chk("post_a_busy", 32'(a_busy), 32'h0);
        chk("post_a_cnt",  32'(a_cnt), 32'h0);
        start = 1'b1;
        tick(1);                              // fresh start edge
        tick(11);
        chk("fresh_a_done_early", 32'(a_done), 32'h0);
        tick(1);
        chk("fresh_a_done", 32'(a_done), 32'h1);
        chk("fresh_a_sig",  a_sig, 32'h0000_00FF);
        chk("fresh_a_go",   32'(a_go), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
